// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan driver.
// The segment table is high-true, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    localparam int DIGITS = 4;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to 7-segment decode with selectable polarity.
// ACTIVE_LOW=1 inverts the high-true table entry.
module seg7_hex_decoder
    import seg7_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = HEX_SEG[nibble] ^ {7{ACTIVE_LOW}};
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// 4-digit multiplexed 7-segment scan driver with blanking gap between
// digits and frame-aligned commit of shadowed display data.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int PRESCALE       = 50000,
    parameter int BLANK_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        LOAD,
    input  logic [15:0] DATA,
    input  logic [3:0]  DP,
    input  logic [3:0]  EN_MASK,
    output logic [6:0]  SEG,
    output logic        SEG_DP,
    output logic [3:0]  AN,
    output logic [1:0]  S_IDX,
    output logic        PENDING,
    output logic        FRAME
);

    localparam int MAXC = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0] idx_nxt;
    logic last, wrap;

    logic [15:0] sh_data, act_data, act_data_nxt;
    logic [3:0] sh_dp, act_dp, act_dp_nxt;
    logic [3:0] sh_en, act_en, act_en_nxt;
    logic commit;

    logic [3:0] nibble;
    logic [6:0] dec_seg;
    logic [6:0] seg_nxt;
    logic dp_nxt;
    logic [3:0] an_nxt;

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= BLANK;
            cnt   <= '0;
            S_IDX <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            S_IDX <= idx_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        idx_nxt   = S_IDX;
        last      = 1'b0;
        wrap      = 1'b0;
        unique case (state)
            BLANK: last = (cnt == CW'(BLANK_CYCLES - 1));
            SHOW:  last = (cnt == CW'(PRESCALE - 1));
            default: last = 1'b0;
        endcase
        if (last) begin
            cnt_nxt = '0;
            if (state == SHOW) begin
                state_nxt = BLANK;
                idx_nxt   = S_IDX + 2'd1;
                wrap      = (S_IDX == 2'(DIGITS - 1));
            end else begin
                state_nxt = SHOW;
            end
        end
    end

    assign commit = wrap && PENDING;

    always_comb begin
        act_data_nxt = commit ? sh_data : act_data;
        act_dp_nxt   = commit ? sh_dp   : act_dp;
        act_en_nxt   = commit ? sh_en   : act_en;
    end

    // Commit reads the old shadow, so a LOAD on the wrap edge stays pending
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sh_data  <= '0;
            sh_dp    <= '0;
            sh_en    <= '0;
            act_data <= '0;
            act_dp   <= '0;
            act_en   <= '0;
            PENDING  <= 1'b0;
            FRAME    <= 1'b0;
        end else begin
            act_data <= act_data_nxt;
            act_dp   <= act_dp_nxt;
            act_en   <= act_en_nxt;
            FRAME    <= wrap;
            if (LOAD) begin
                sh_data <= DATA;
                sh_dp   <= DP;
                sh_en   <= EN_MASK;
                PENDING <= 1'b1;
            end else if (commit) begin
                PENDING <= 1'b0;
            end
        end
    end

    assign nibble = act_data_nxt[{idx_nxt, 2'b00} +: 4];

    seg7_hex_decoder #(
        .ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_dec (
        .nibble(nibble),
        .seg   (dec_seg)
    );

    // Outputs are computed from next state so they register glitch-free
    always_comb begin
        seg_nxt = {7{SEG_ACTIVE_LOW}};
        dp_nxt  = SEG_ACTIVE_LOW;
        an_nxt  = {4{AN_ACTIVE_LOW}};
        if (state_nxt == SHOW) begin
            seg_nxt = dec_seg;
            dp_nxt  = act_dp_nxt[idx_nxt] ^ SEG_ACTIVE_LOW;
            if (act_en_nxt[idx_nxt]) begin
                an_nxt[idx_nxt] = ~AN_ACTIVE_LOW;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            SEG    <= {7{SEG_ACTIVE_LOW}};
            SEG_DP <= SEG_ACTIVE_LOW;
            AN     <= {4{AN_ACTIVE_LOW}};
        end else begin
            SEG    <= seg_nxt;
            SEG_DP <= dp_nxt;
            AN     <= an_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (PRESCALE=4, BLANK_CYCLES=1).
// Reference model derives outputs from the cycle count since reset.
module tb_seg7_scan_driver;

    localparam int PRE = 4;
    localparam int BLK = 1;
    localparam int DIG = PRE + BLK;
    localparam int FRM = 4 * DIG;

    logic        CLK = 1'b0;
    logic        RST;
    logic        LOAD;
    logic [15:0] DATA;
    logic [3:0]  DP;
    logic [3:0]  EN_MASK;
    logic [6:0]  SEG;
    logic        SEG_DP;
    logic [3:0]  AN;
    logic [1:0]  S_IDX;
    logic        PENDING;
    logic        FRAME;

    seg7_scan_driver #(
        .PRESCALE      (PRE),
        .BLANK_CYCLES  (BLK),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .LOAD   (LOAD),
        .DATA   (DATA),
        .DP     (DP),
        .EN_MASK(EN_MASK),
        .SEG    (SEG),
        .SEG_DP (SEG_DP),
        .AN     (AN),
        .S_IDX  (S_IDX),
        .PENDING(PENDING),
        .FRAME  (FRAME)
    );

    always #5 CLK = ~CLK;

    // High-true glyphs {g..a}
    logic [6:0] glyph [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    int checks = 0;
    int failures = 0;
    int k = 0;

    logic [15:0] m_sh_data, m_act_data;
    logic [3:0]  m_sh_dp, m_act_dp, m_sh_en, m_act_en;
    logic        m_pend;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
        end
    endtask

    task automatic model_reset();
        m_sh_data = '0; m_act_data = '0;
        m_sh_dp = '0; m_act_dp = '0;
        m_sh_en = '0; m_act_en = '0;
        m_pend = 1'b0;
        k = 0;
    endtask

    // Clock edge from cycle k to k+1 with the inputs present at that edge
    task automatic model_edge();
        if (((k + 1) % FRM) == 0 && m_pend) begin
            m_act_data = m_sh_data;
            m_act_dp = m_sh_dp;
            m_act_en = m_sh_en;
            m_pend = 1'b0;
        end
        if (LOAD) begin
            m_sh_data = DATA;
            m_sh_dp = DP;
            m_sh_en = EN_MASK;
            m_pend = 1'b1;
        end
        k++;
    endtask

    task automatic check_all();
        int d;
        bit show;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic e_dp;
        logic [3:0] nib;
        d = (k / DIG) % 4;
        show = (k % DIG) >= BLK;
        nib = m_act_data[d*4 +: 4];
        e_an = 4'hF;
        e_seg = 7'h7F;
        e_dp = 1'b1;
        if (show) begin
            e_seg = ~glyph[nib];
            e_dp = ~m_act_dp[d];
            if (m_act_en[d]) e_an[d] = 1'b0;
        end
        check("s_idx", 32'(S_IDX), 32'(d));
        check("an", 32'(AN), 32'(e_an));
        check("seg", 32'(SEG), 32'(e_seg));
        check("seg_dp", 32'(SEG_DP), 32'(e_dp));
        check("pending", 32'(PENDING), 32'(m_pend));
        check("frame", 32'(FRAME), 32'(k > 0 && (k % FRM) == 0));
        check("an_onehot", 32'($countones(~AN) <= 1), 32'd1);
    endtask

    task automatic run(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            model_edge();
            #1;
            check_all();
            LOAD = 1'b0;
            if (rnd) begin
                LOAD = ($urandom_range(0, 11) == 0) ||
                       ((((k + 1) % FRM) == 0) && $urandom_range(0, 1) == 1);
                DATA = 16'($urandom);
                DP = 4'($urandom);
                EN_MASK = 4'($urandom);
            end
        end
    endtask

    task automatic run_to(input int phase);
        int guard;
        guard = 0;
        while ((k % FRM) != phase && guard < 2 * FRM) begin
            run(1, 1'b0);
            guard++;
        end
        check("run_to_bound", 32'((k % FRM) == phase), 32'd1);
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] p,
                        input logic [3:0] e);
        LOAD = 1'b1;
        DATA = d;
        DP = p;
        EN_MASK = e;
        run(1, 1'b0);
    endtask

    initial begin
        RST = 1'b1;
        LOAD = 1'b0;
        DATA = '0;
        DP = '0;
        EN_MASK = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_all();
        @(negedge CLK);
        RST = 1'b0;

        // Initial load waits for the first frame wrap
        load(16'h3210, 4'h0, 4'hF);
        run(2 * FRM, 1'b0);

        // Digit 2 disabled, decimal points on
        run_to(3);
        load(16'h4567, 4'h5, 4'b1011);
        run(2 * FRM, 1'b0);

        // Last LOAD before the wrap wins
        run_to(3);
        load(16'hAAAA, 4'h0, 4'hF);
        run(5, 1'b0);
        load(16'hBBBB, 4'h0, 4'hF);
        run(FRM, 1'b0);

        // Queue a shadow, then LOAD again on the commit edge
        run_to(5);
        load(16'h89CD, 4'h2, 4'hF);
        run_to(FRM - 1);
        load(16'hEF01, 4'h8, 4'hF);
        run(2 * FRM, 1'b0);

        // Asynchronous reset during digit 2 SHOW
        run_to(2 * DIG + 2);
        #2;
        RST = 1'b1;
        #1;
        check("an_async_rst", 32'(AN), 32'hF);
        check("sidx_async_rst", 32'(S_IDX), 32'd0);
        check("pend_async_rst", 32'(PENDING), 32'd0);
        model_reset();
        @(posedge CLK);
        #1;
        check_all();
        @(negedge CLK);
        RST = 1'b0;
        run(2 * FRM, 1'b0);

        // Randomized traffic
        run(400, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
